phase_track_core: RTL and testbench

PHASE_TRACK_CORE -- requirements
Module: phase_track_core

---
 rtl/phase_track_core.sv | 189 ++++++++++++++++++
 tb/tb_phase_track_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_track_core.sv
// Multi-phase bit-clock recovery: counts data strobes against NUM_PHASE staggered gates,
// locks onto the strongest phase at end of preamble and optionally keeps re-tracking it.
module phase_track_core #(
    parameter int NUM_PHASE = 16,
    parameter int CNT_WIDTH = 16,
    parameter int DIV_WIDTH = 8,
    parameter int WIN_WIDTH = 12
) (
    input  logic                         clk_fast,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         preamble_end,
    input  logic                         adc_pulse,
    input  logic [DIV_WIDTH-1:0]         div_ratio,
    input  logic [DIV_WIDTH-1:0]         gate_w,
    input  logic                         track_mode,
    input  logic [WIN_WIDTH-1:0]         track_win,
    input  logic [CNT_WIDTH-1:0]         hyst,
    input  logic [CNT_WIDTH-1:0]         min_count,
    output logic                         sync_clk,
    output logic                         sync_locked,
    output logic                         lock_fail,
    output logic [$clog2(NUM_PHASE)-1:0] sel_phase_idx,
    output logic [CNT_WIDTH-1:0]         best_count,
    output logic                         relock_pulse,
    output logic [1:0]                   state
);
    localparam int IW = $clog2(NUM_PHASE);
    localparam int PW = DIV_WIDTH + 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2,
        FAIL   = 2'd3
    } state_t;

    state_t cur_state, next_state;

    logic [DIV_WIDTH-1:0] phase_cnt  [NUM_PHASE];
    logic [DIV_WIDTH-1:0] phase_init [NUM_PHASE];
    logic [CNT_WIDTH-1:0] hit_cnt    [NUM_PHASE];
    logic [NUM_PHASE-1:0] gate;
    logic [WIN_WIDTH-1:0] win_cnt;
    logic                 enable_d, pre_end_d, armed;

    logic [DIV_WIDTH-1:0] div_eff, gate_raw, gate_eff, div_last;
    logic [WIN_WIDTH-1:0] win_eff;
    logic [CNT_WIDTH-1:0] max_val;
    logic [IW-1:0]        max_idx;
    logic [CNT_WIDTH:0]   switch_thresh;
    logic                 rise, phase0_wrap, search_eval, lock_ok, window_eval, count_en;

    always_comb begin
        div_eff  = (div_ratio < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_ratio;
        div_last = div_eff - DIV_WIDTH'(1);
        gate_raw = (gate_w != '0) ? gate_w : (div_eff >> 1);
        gate_eff = gate_raw;
        if (gate_raw == '0)
            gate_eff = DIV_WIDTH'(1);
        else if (gate_raw > div_last)
            gate_eff = div_last;
        win_eff = (track_win == '0) ? WIN_WIDTH'(1) : track_win;
        for (int i = 0; i < NUM_PHASE; i++)
            phase_init[i] = DIV_WIDTH'((PW'(div_eff) * PW'(i)) / PW'(NUM_PHASE));
    end

    // Strict compare while scanning upward keeps the lowest index on ties.
    always_comb begin
        max_val = hit_cnt[0];
        max_idx = '0;
        for (int i = 1; i < NUM_PHASE; i++) begin
            if (hit_cnt[i] > max_val) begin
                max_val = hit_cnt[i];
                max_idx = IW'(i);
            end
        end
    end

    always_comb begin
        rise          = enable & ~enable_d;
        phase0_wrap   = (phase_cnt[0] >= div_last);
        search_eval   = enable && !rise && (cur_state == SEARCH) && armed
                        && preamble_end && !pre_end_d;
        lock_ok       = (max_val >= min_count);
        window_eval   = enable && !rise && (cur_state == LOCKED) && track_mode
                        && phase0_wrap && (win_cnt >= win_eff - WIN_WIDTH'(1));
        count_en      = enable && !rise && !search_eval && !window_eval
                        && ((cur_state == SEARCH) || ((cur_state == LOCKED) && track_mode));
        switch_thresh = {1'b0, hit_cnt[sel_phase_idx]} + {1'b0, hyst};
    end

    always_comb begin
        next_state = cur_state;
        if (!enable)
            next_state = IDLE;
        else if (rise)
            next_state = SEARCH;
        else if (search_eval)
            next_state = lock_ok ? LOCKED : FAIL;
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n)
            cur_state <= IDLE;
        else
            cur_state <= next_state;
    end

    // Phase counters free-run and only reload their stagger on an enable rise.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASE; i++) begin
                phase_cnt[i] <= '0;
                hit_cnt[i]   <= '0;
            end
            gate <= '0;
        end else begin
            for (int i = 0; i < NUM_PHASE; i++) begin
                gate[i] <= (phase_cnt[i] < gate_eff);
                if (rise)
                    phase_cnt[i] <= phase_init[i];
                else if (phase_cnt[i] >= div_last)
                    phase_cnt[i] <= '0;
                else
                    phase_cnt[i] <= phase_cnt[i] + DIV_WIDTH'(1);
                if (rise || search_eval || window_eval)
                    hit_cnt[i] <= '0;
                else if (count_en && adc_pulse && gate[i] && (hit_cnt[i] != '1))
                    hit_cnt[i] <= hit_cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            enable_d      <= 1'b0;
            pre_end_d     <= 1'b0;
            armed         <= 1'b0;
            win_cnt       <= '0;
            sync_locked   <= 1'b0;
            lock_fail     <= 1'b0;
            sel_phase_idx <= '0;
            best_count    <= '0;
            relock_pulse  <= 1'b0;
        end else begin
            enable_d     <= enable;
            pre_end_d    <= preamble_end;
            relock_pulse <= 1'b0;
            if (rise)
                armed <= 1'b0;
            else if (cur_state == SEARCH)
                armed <= 1'b1;
            if (!enable || rise || search_eval || window_eval)
                win_cnt <= '0;
            else if ((cur_state == LOCKED) && track_mode && phase0_wrap)
                win_cnt <= win_cnt + WIN_WIDTH'(1);
            if (!enable) begin
                sync_locked <= 1'b0;
                lock_fail   <= 1'b0;
            end else if (rise) begin
                sync_locked   <= 1'b0;
                lock_fail     <= 1'b0;
                sel_phase_idx <= '0;
                best_count    <= '0;
            end else if (search_eval) begin
                if (lock_ok) begin
                    sync_locked   <= 1'b1;
                    sel_phase_idx <= max_idx;
                    best_count    <= max_val;
                end else begin
                    lock_fail     <= 1'b1;
                    sync_locked   <= 1'b0;
                    sel_phase_idx <= '0;
                end
            end else if (window_eval) begin
                best_count <= max_val;
                if ({1'b0, max_val} > switch_thresh) begin
                    sel_phase_idx <= max_idx;
                    relock_pulse  <= 1'b1;
                end
            end
        end
    end

    assign sync_clk = (cur_state == LOCKED) ? gate[sel_phase_idx] : gate[0];
    assign state    = cur_state;

endmodule

// File: tb/tb_phase_track_core.sv
// Directed bench for phase_track_core: lock, fail, arming, ties, tracking with hysteresis,
// enable/reset behaviour and counter saturation, with hand-derived expectations.
module tb_phase_track_core;
    logic        clk_fast = 1'b0;
    logic        rst_n;
    logic        enable, preamble_end, adc_pulse, track_mode;
    logic [7:0]  div_ratio, gate_w;
    logic [11:0] track_win;
    logic [15:0] hyst, min_count;
    logic        sync_clk, sync_locked, lock_fail, relock_pulse;
    logic [3:0]  sel_phase_idx;
    logic [15:0] best_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int c = 0;
    int relocks;

    phase_track_core dut (
        .clk_fast(clk_fast), .rst_n(rst_n), .enable(enable), .preamble_end(preamble_end),
        .adc_pulse(adc_pulse), .div_ratio(div_ratio), .gate_w(gate_w),
        .track_mode(track_mode), .track_win(track_win), .hyst(hyst), .min_count(min_count),
        .sync_clk(sync_clk), .sync_locked(sync_locked), .lock_fail(lock_fail),
        .sel_phase_idx(sel_phase_idx), .best_count(best_count),
        .relock_pulse(relock_pulse), .state(state)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // c counts edges since the enable-rise edge; a pulse driven while c%16==(17-p)%16
    // with div 16 lands inside phase p's gate (lowest phase of the gate run for gate_w=0).
    task automatic apply_stimulus(input logic pulse);
        adc_pulse = pulse;
        @(posedge clk_fast);
        #1;
        c++;
    endtask

    task automatic rise_enable();
        enable = 1'b1;
        apply_stimulus(1'b0);
        c = 0;
    endtask

    task automatic drop_enable();
        enable       = 1'b0;
        preamble_end = 1'b0;
        apply_stimulus(1'b0);
    endtask

    task automatic send_pulses(input int na, input int oa, input int nb, input int ob);
        int ka = 0;
        int kb = 0;
        int guard = 0;
        logic p;
        while ((ka < na || kb < nb) && guard < 4000) begin
            p = 1'b0;
            if (ka < na && (c % 16) == oa) begin p = 1'b1; ka++; end
            if (kb < nb && (c % 16) == ob) begin p = 1'b1; kb++; end
            apply_stimulus(p);
            guard++;
        end
        check_output("pulse_budget", int'(ka == na && kb == nb), 1);
    endtask

    task automatic align_to(input int r);
        int guard = 0;
        while ((c % 16) != r && guard < 16) begin
            apply_stimulus(1'b0);
            guard++;
        end
    endtask

    task automatic lock_eval();
        align_to(3);
        preamble_end = 1'b1;
        apply_stimulus(1'b0);
    endtask

    // Runs until eight phase-0 wraps, pulsing phase 7 (c%16==10) and phase 5 (c%16==12).
    task automatic track_window(input int n7, input int n5, output int seen);
        int wraps = 0;
        int k7 = 0;
        int k5 = 0;
        int guard = 0;
        logic p, wrap;
        seen = 0;
        while (wraps < 8 && guard < 200) begin
            wrap = ((c % 16) == 15);
            p = 1'b0;
            if (k7 < n7 && (c % 16) == 10) begin p = 1'b1; k7++; end
            if (k5 < n5 && (c % 16) == 12) begin p = 1'b1; k5++; end
            apply_stimulus(p);
            if (wrap) wraps++;
            if (relock_pulse) seen++;
            guard++;
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; preamble_end = 1'b0; adc_pulse = 1'b0;
        track_mode = 1'b0; div_ratio = 8'd16; gate_w = 8'd0; track_win = 12'd0;
        hyst = 16'd0; min_count = 16'd1;
        repeat (3) @(posedge clk_fast);
        #1;
        check_output("rst_state", state, 0);
        check_output("rst_sync_clk", sync_clk, 0);
        check_output("rst_best", best_count, 0);
        rst_n = 1'b1;
        apply_stimulus(1'b0);

        $display("[TB] lock on phase 5 with wide gate");
        rise_enable();
        check_output("search_entry", state, 1);
        send_pulses(20, 12, 0, 0);
        lock_eval();
        check_output("lock_state", state, 2);
        check_output("lock_sync_locked", sync_locked, 1);
        check_output("lock_sel", sel_phase_idx, 5);
        check_output("lock_best", best_count, 20);
        align_to(12);
        check_output("sync_clk_high", sync_clk, 1);
        align_to(4);
        check_output("sync_clk_low", sync_clk, 0);

        $display("[TB] enable drop and re-rise");
        drop_enable();
        check_output("drop_idle", state, 0);
        rise_enable();
        check_output("rerise_state", state, 1);
        check_output("rerise_locked", sync_locked, 0);
        check_output("rerise_best", best_count, 0);

        $display("[TB] preamble_end during arming cycle and already high");
        preamble_end = 1'b1;
        repeat (20) apply_stimulus(1'b0);
        check_output("arm_ignore", state, 1);
        enable = 1'b0;
        apply_stimulus(1'b0);
        rise_enable();
        repeat (20) apply_stimulus(1'b0);
        check_output("pre_high_ignore", state, 1);

        $display("[TB] too few pulses fails");
        drop_enable();
        gate_w = 8'd1; min_count = 16'd10;
        rise_enable();
        send_pulses(4, 12, 0, 0);
        lock_eval();
        check_output("fail_state", state, 3);
        check_output("fail_flag", lock_fail, 1);
        check_output("fail_locked", sync_locked, 0);
        check_output("fail_sel", sel_phase_idx, 0);
        repeat (10) apply_stimulus(1'b0);
        check_output("fail_persist", state, 3);

        $display("[TB] tie between phases 3 and 9");
        drop_enable();
        min_count = 16'd1;
        rise_enable();
        send_pulses(3, 14, 3, 8);
        lock_eval();
        check_output("tie_sel", sel_phase_idx, 3);
        check_output("tie_best", best_count, 3);

        $display("[TB] tracking with hysteresis");
        drop_enable();
        track_mode = 1'b1; track_win = 12'd8; hyst = 16'd2;
        rise_enable();
        send_pulses(6, 12, 0, 0);
        lock_eval();
        check_output("track_lock_sel", sel_phase_idx, 5);
        check_output("track_lock_best", best_count, 6);
        track_window(8, 3, relocks);
        check_output("win1_relocks", relocks, 1);
        check_output("win1_sel", sel_phase_idx, 7);
        check_output("win1_best", best_count, 8);
        apply_stimulus(1'b0);
        check_output("relock_one_cycle", relock_pulse, 0);
        track_window(4, 5, relocks);
        check_output("win2_relocks", relocks, 0);
        check_output("win2_sel", sel_phase_idx, 7);
        check_output("win2_best", best_count, 5);
        align_to(10);
        check_output("track_clk_high", sync_clk, 1);
        apply_stimulus(1'b0);
        check_output("track_clk_low", sync_clk, 0);

        $display("[TB] reset mid-search");
        drop_enable();
        track_mode = 1'b0;
        rise_enable();
        send_pulses(3, 12, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_state", state, 0);
        check_output("mid_rst_sel", sel_phase_idx, 0);
        check_output("mid_rst_best", best_count, 0);
        check_output("mid_rst_relock", relock_pulse, 0);
        check_output("mid_rst_sync_clk", sync_clk, 0);
        enable = 1'b0;
        apply_stimulus(1'b0);
        rst_n = 1'b1;
        repeat (5) apply_stimulus(1'b0);
        check_output("post_rst_idle", state, 0);

        $display("[TB] hit counter saturation");
        div_ratio = 8'd255; gate_w = 8'd254;
        rise_enable();
        repeat (66000) apply_stimulus(1'b1);
        preamble_end = 1'b1;
        apply_stimulus(1'b0);
        check_output("sat_state", state, 2);
        check_output("sat_best", best_count, 65535);
        check_output("sat_sel", sel_phase_idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
